// File: rtl/lcd_read_cycle_pkg.sv
// -----------------------------------------------------------------------------
// lcd_read_cycle_pkg
// Shared definitions for the LCD read-cycle sequencer: FSM state encoding,
// RS values, busy-flag bit position, address field width and a helper that
// sizes the phase timer.
// -----------------------------------------------------------------------------
package lcd_read_cycle_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_E_HIGH,
      ST_E_LOW,
      ST_CHECK,
      ST_DONE
   } state_e;

   // RS levels on the LCD bus
   localparam logic RS_CMD  = 1'b0;   // instruction register / status read
   localparam logic RS_DATA = 1'b1;   // DDRAM/CGRAM data read

   localparam int unsigned DB_W       = 8;
   localparam int unsigned BF_BIT     = 7;
   localparam int unsigned ADDR_W     = 7;
   localparam int unsigned POLL_CNT_W = 8;

   // Width needed to hold (max_cycles - 1); never narrower than one bit.
   function automatic int unsigned timer_width(input int unsigned max_cycles);
      return (max_cycles > 1) ? $clog2(max_cycles) : 1;
   endfunction

endpackage

// File: rtl/lcd_phase_timer.sv
// -----------------------------------------------------------------------------
// lcd_phase_timer
// Loadable down-counter used to time the E-high and E-low phases of a read.
// Loading value V makes done_o assert V cycles after the load edge, i.e. a
// phase lasting V+1 cycles is timed by loading V.
//
// Ports:
//   clk        - slow clock
//   rst        - synchronous active-high reset (counter cleared)
//   load_i     - load load_val_i into the counter at the next edge
//   load_val_i - value to load (phase length minus one)
//   done_o     - counter has reached zero (current phase ends this cycle)
// -----------------------------------------------------------------------------
module lcd_phase_timer #(
   parameter int unsigned CNT_W = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_i,
   input  logic [CNT_W-1:0] load_val_i,
   output logic             done_o
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign done_o = (cnt_q == '0);

endmodule

// File: rtl/lcd_read_cycle.sv
// -----------------------------------------------------------------------------
// lcd_read_cycle
// HD44780-style read bus cycle sequencer (RW=1). Performs a single status read,
// a single data read, or a busy-poll loop of status reads that ends when BF=0
// or when MAX_POLLS reads have been made (timeout).
//
// Parameters:
//   E_CYCLES     - cycles E is held high per read (>=1)
//   RECOV_CYCLES - cycles E is held low after its falling edge (>=1)
//   MAX_POLLS    - status reads allowed in poll mode (1..255)
//
// Ports:
//   clk        - slow clock
//   rst        - synchronous active-high reset
//   rd_enable  - start request, sampled in IDLE only
//   reg_sel    - 0 status read, 1 data read (latched at start)
//   poll       - repeat status reads while BF=1 (latched, ignored for data)
//   db_in      - LCD data bus input path
//   rs_out     - LCD RS
//   rw_out     - LCD RW
//   e_out      - LCD E
//   db_release - 1 = DB drivers tri-stated
//   rd_data    - last sampled bus value
//   busy       - BF of last status read
//   addr       - address counter of last status read
//   rd_finish  - one-cycle completion pulse
//   timeout    - poll limit reached, held until next accepted start
// -----------------------------------------------------------------------------
module lcd_read_cycle
   import lcd_read_cycle_pkg::*;
#(
   parameter int unsigned E_CYCLES     = 1,
   parameter int unsigned RECOV_CYCLES = 1,
   parameter int unsigned MAX_POLLS    = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rd_enable,
   input  logic              reg_sel,
   input  logic              poll,
   input  logic [DB_W-1:0]   db_in,
   output logic              rs_out,
   output logic              rw_out,
   output logic              e_out,
   output logic              db_release,
   output logic [DB_W-1:0]   rd_data,
   output logic              busy,
   output logic [ADDR_W-1:0] addr,
   output logic              rd_finish,
   output logic              timeout
);

   localparam int unsigned TMR_MAX = (E_CYCLES > RECOV_CYCLES) ? E_CYCLES : RECOV_CYCLES;
   localparam int unsigned TMR_W   = timer_width(TMR_MAX);
   localparam logic [TMR_W-1:0]      E_LOAD      = TMR_W'(E_CYCLES - 1);
   localparam logic [TMR_W-1:0]      R_LOAD      = TMR_W'(RECOV_CYCLES - 1);
   localparam logic [POLL_CNT_W-1:0] MAX_POLLS_C = POLL_CNT_W'(MAX_POLLS);

   state_e                  state_q;
   logic                    reg_sel_q;
   logic                    poll_q;
   logic [POLL_CNT_W-1:0]   poll_cnt_q;
   logic                    rs_q;
   logic                    rw_q;
   logic                    e_q;
   logic                    rel_q;
   logic [DB_W-1:0]         rd_data_q;
   logic                    busy_q;
   logic [ADDR_W-1:0]       addr_q;
   logic                    rd_finish_q;
   logic                    timeout_q;

   logic                    tmr_load;
   logic [TMR_W-1:0]        tmr_val;
   logic                    tmr_done;

   // The timer is loaded on the edge that enters each timed phase, so its
   // done tick coincides with the last cycle of that phase.
   always_comb begin
      tmr_load = 1'b0;
      tmr_val  = E_LOAD;
      if (state_q == ST_SETUP) begin
         tmr_load = 1'b1;
         tmr_val  = E_LOAD;
      end else if ((state_q == ST_E_HIGH) && tmr_done) begin
         tmr_load = 1'b1;
         tmr_val  = R_LOAD;
      end
   end

   lcd_phase_timer #(
      .CNT_W (TMR_W)
   ) u_phase_timer (
      .clk        (clk),
      .rst        (rst),
      .load_i     (tmr_load),
      .load_val_i (tmr_val),
      .done_o     (tmr_done)
   );

   // Single FSM process; every pin output is registered and updated on the
   // edge that enters the state it belongs to.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         reg_sel_q   <= RS_CMD;
         poll_q      <= 1'b0;
         poll_cnt_q  <= '0;
         rs_q        <= 1'b0;
         rw_q        <= 1'b0;
         e_q         <= 1'b0;
         rel_q       <= 1'b0;
         rd_data_q   <= '0;
         busy_q      <= 1'b0;
         addr_q      <= '0;
         rd_finish_q <= 1'b0;
         timeout_q   <= 1'b0;
      end else begin
         rd_finish_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (rd_enable) begin
                  reg_sel_q  <= reg_sel;
                  // Poll mode only makes sense for status reads.
                  poll_q     <= poll && (reg_sel != RS_DATA);
                  poll_cnt_q <= '0;
                  timeout_q  <= 1'b0;
                  rs_q       <= reg_sel;
                  rw_q       <= 1'b1;
                  rel_q      <= 1'b1;
                  state_q    <= ST_SETUP;
               end
            end

            ST_SETUP: begin
               e_q     <= 1'b1;
               state_q <= ST_E_HIGH;
            end

            ST_E_HIGH: begin
               if (tmr_done) begin
                  e_q       <= 1'b0;
                  rd_data_q <= db_in;
                  if (reg_sel_q == RS_CMD) begin
                     busy_q <= db_in[BF_BIT];
                     addr_q <= db_in[ADDR_W-1:0];
                  end
                  poll_cnt_q <= poll_cnt_q + POLL_CNT_W'(1);
                  state_q    <= ST_E_LOW;
               end
            end

            ST_E_LOW: begin
               if (tmr_done) begin
                  state_q <= ST_CHECK;
               end
            end

            ST_CHECK: begin
               if (poll_q && busy_q && (poll_cnt_q < MAX_POLLS_C)) begin
                  // RS/RW/release stay asserted across poll iterations.
                  state_q <= ST_SETUP;
               end else begin
                  if (poll_q && busy_q) begin
                     timeout_q <= 1'b1;
                  end
                  rd_finish_q <= 1'b1;
                  rs_q        <= 1'b0;
                  rw_q        <= 1'b0;
                  rel_q       <= 1'b0;
                  state_q     <= ST_DONE;
               end
            end

            ST_DONE: begin
               state_q <= ST_IDLE;
            end

            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign rs_out     = rs_q;
   assign rw_out     = rw_q;
   assign e_out      = e_q;
   assign db_release = rel_q;
   assign rd_data    = rd_data_q;
   assign busy       = busy_q;
   assign addr       = addr_q;
   assign rd_finish  = rd_finish_q;
   assign timeout    = timeout_q;

endmodule
